// File: rtl/leaf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_pkg
//  Description : Shared definitions for the leaf shell output side. Holds the
//                packet field layout for the default configuration, the
//                credit counter width helper and the packed packet struct.
//  Revision    : 1.0 - initial release
// ============================================================================
package leaf_pkg;

    // Default field widths (match the default leaf_out_arbiter parameters)
    localparam int c_payload_bits = 32;
    localparam int c_leaf_bits    = 5;
    localparam int c_port_bits    = 4;
    localparam int c_addr_bits    = 7;

    // Packet field offsets, payload in the LSBs, valid flag in the MSB
    localparam int c_payload_lsb  = 0;
    localparam int c_addr_lsb     = c_payload_lsb + c_payload_bits;
    localparam int c_port_lsb     = c_addr_lsb + c_addr_bits;
    localparam int c_leaf_lsb     = c_port_lsb + c_port_bits;
    localparam int c_valid_bit    = c_leaf_lsb + c_leaf_bits;
    localparam int c_packet_bits  = c_valid_bit + 1;

    // A credit counter must hold the full remote depth 2^bram_addr_bits,
    // which needs one bit more than the BRAM address.
    function automatic int credit_width(input int bram_addr_bits);
        return bram_addr_bits + 1;
    endfunction

    typedef struct packed {
        logic                      valid;
        logic [c_leaf_bits-1:0]    dest_leaf;
        logic [c_port_bits-1:0]    dest_port;
        logic [c_addr_bits-1:0]    addr;
        logic [c_payload_bits-1:0] payload;
    } leaf_pkt_t;

endpackage
`default_nettype wire

// File: rtl/leaf_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_rr_arbiter
//  Description : Combinational round-robin arbiter. Picks the first asserted
//                request at or above i_ptr, wrapping around, and returns it
//                as a one-hot grant (all zero when nothing requests).
//  Ports       : i_req   [NUM_REQ]  request vector
//                i_ptr   [PTR_BITS] highest-priority index (< NUM_REQ)
//                o_grant [NUM_REQ]  one-hot or zero grant
//  Revision    : 1.0 - initial release
// ============================================================================
module leaf_rr_arbiter #(
    parameter int NUM_REQ  = 7,
    parameter int PTR_BITS = 4
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [PTR_BITS-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_grant
);

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [2*NUM_REQ-1:0] w_gnt_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [NUM_REQ-1:0]   w_seen;
    logic [NUM_REQ-1:0]   w_gnt_rot;

    // Rotate right by the pointer so the priority start sits at bit 0; the
    // doubled vector makes the wrap-around fall out of a plain shift.
    assign w_req_dbl = {i_req, i_req};
    assign w_req_rot = NUM_REQ'(w_req_dbl >> i_ptr);

    // Fixed-priority pick on the rotated vector: w_seen[k] is set when any
    // lower rotated bit already requested.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_seen
        if (k == 0) begin : g_first
            assign w_seen[k] = 1'b0;
        end else begin : g_rest
            assign w_seen[k] = w_seen[k-1] | w_req_rot[k-1];
        end
    end

    assign w_gnt_rot = w_req_rot & ~w_seen;

    // Rotate the grant back and fold the two halves together.
    assign w_gnt_dbl = {{NUM_REQ{1'b0}}, w_gnt_rot} << i_ptr;
    assign o_grant   = w_gnt_dbl[NUM_REQ-1:0] | w_gnt_dbl[2*NUM_REQ-1:NUM_REQ];

endmodule
`default_nettype wire

// File: rtl/leaf_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_out_arbiter
//  Description : Output half of the leaf shell. Merges NUM_OUT_PORTS user
//                streams into one registered BFT packet stream with
//                round-robin arbitration, a per-port destination table,
//                per-port sequence addresses, per-port credit flow control
//                and resend gating.
//  Ports       : clk, reset (sync, active-high)
//                din_leaf_user2interface / vld_user2interface : user streams
//                ack_interface2user  : same-cycle accept, one-hot or zero
//                resend              : blocks all grants, blanks dout
//                cfg_*               : destination table write
//                credit_upd_*        : freespace (credit) return
//                dout_leaf_interface2bft : {valid, leaf, port, addr, payload}
//                credit_zero         : per-port "no credit left"
//  Options     : LEAF_ARB_STATS_EN adds stat_pkt_count / stat_stall_count,
//                32-bit wrapping counters per port.
//  Revision    : 1.0 - initial release
// ============================================================================
module leaf_out_arbiter #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 7,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    resend,
    input  logic                                    cfg_wr_en,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port_sel,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
    input  logic                                    credit_upd_vld,
    input  logic [NUM_PORT_BITS-1:0]                credit_upd_port,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
    output logic [NUM_OUT_PORTS-1:0]                credit_zero
`ifdef LEAF_ARB_STATS_EN
   ,output logic [NUM_OUT_PORTS*32-1:0]             stat_pkt_count,
    output logic [NUM_OUT_PORTS*32-1:0]             stat_stall_count
`endif
);

    import leaf_pkg::*;

    localparam int c_credit_bits = credit_width(NUM_BRAM_ADDR_BITS);
    localparam int c_credit_max  = 2 ** NUM_BRAM_ADDR_BITS;
    localparam logic [c_credit_bits-1:0] c_credit_init = c_credit_bits'(c_credit_max);

    logic [NUM_OUT_PORTS-1:0]                    w_req;
    logic [NUM_OUT_PORTS-1:0]                    w_grant;
    logic [NUM_OUT_PORTS-1:0][PACKET_BITS-1:0]   w_pkt_or;
    logic [NUM_OUT_PORTS-1:0][NUM_PORT_BITS-1:0] w_ptr_or;
    logic [PACKET_BITS-1:0]                      r_dout;
    logic [NUM_PORT_BITS-1:0]                    r_rr_ptr;

    leaf_rr_arbiter #(
        .NUM_REQ  (NUM_OUT_PORTS),
        .PTR_BITS (NUM_PORT_BITS)
    ) u_rr_arbiter (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    // ------------------------------------------------------------------
    // Per-port table entry, sequence address and credit counter. Indices
    // at or above NUM_OUT_PORTS never match any port, so out-of-range
    // config writes and credit updates are dropped naturally.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_port
        logic                      r_cfg_valid;
        logic [NUM_LEAF_BITS-1:0]  r_dest_leaf;
        logic [NUM_PORT_BITS-1:0]  r_dest_port;
        logic [NUM_ADDR_BITS-1:0]  r_addr;
        logic [c_credit_bits-1:0]  r_credit;
        logic                      r_credit_zero;
        logic [PAYLOAD_BITS-1:0]   w_payload;
        logic                      w_cfg_hit;
        logic                      w_upd_hit;
        int                        w_credit_sum;
        logic [c_credit_bits-1:0]  w_credit_next;
        logic [PACKET_BITS-1:0]    w_cand;
        logic [NUM_PORT_BITS-1:0]  w_ptr_cand;

        assign w_payload = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign w_cfg_hit = cfg_wr_en && (cfg_port_sel == NUM_PORT_BITS'(i));
        assign w_upd_hit = credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(i));

        assign w_req[i] = vld_user2interface[i] && r_cfg_valid &&
                          (r_credit != '0) && !resend;

        // Send and update in one cycle combine before saturation, so a full
        // counter plus an update minus a send still lands on the maximum.
        always_comb begin
            w_credit_sum = int'(r_credit) - (w_grant[i] ? 1 : 0)
                         + (w_upd_hit ? FREESPACE_UPDATE_SIZE : 0);
            if (w_credit_sum > c_credit_max) begin
                w_credit_next = c_credit_init;
            end else begin
                w_credit_next = c_credit_bits'(w_credit_sum);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cfg_valid   <= 1'b0;
                r_dest_leaf   <= '0;
                r_dest_port   <= '0;
                r_addr        <= '0;
                r_credit      <= c_credit_init;
                r_credit_zero <= 1'b0;
            end else begin
                // The packet of a same-cycle grant is built from the old
                // entry; the new entry takes effect from the next cycle.
                if (w_cfg_hit) begin
                    r_cfg_valid <= 1'b1;
                    r_dest_leaf <= cfg_dest_leaf;
                    r_dest_port <= cfg_dest_port;
                end
                if (w_grant[i]) begin
                    r_addr <= r_addr + NUM_ADDR_BITS'(1);
                end
                r_credit      <= w_credit_next;
                r_credit_zero <= (w_credit_next == '0);
            end
        end

        assign credit_zero[i] = r_credit_zero;

        // Grants are one-hot, so OR-ing the masked candidates is a mux.
        assign w_cand     = w_grant[i] ? {1'b1, r_dest_leaf, r_dest_port, r_addr, w_payload} : '0;
        assign w_ptr_cand = w_grant[i] ? NUM_PORT_BITS'((i + 1) % NUM_OUT_PORTS) : '0;

        if (i == 0) begin : g_first
            assign w_pkt_or[i] = w_cand;
            assign w_ptr_or[i] = w_ptr_cand;
        end else begin : g_rest
            assign w_pkt_or[i] = w_pkt_or[i-1] | w_cand;
            assign w_ptr_or[i] = w_ptr_or[i-1] | w_ptr_cand;
        end

`ifdef LEAF_ARB_STATS_EN
        logic [31:0] r_stat_pkt;
        logic [31:0] r_stat_stall;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_stat_pkt   <= '0;
                r_stat_stall <= '0;
            end else begin
                if (w_grant[i]) begin
                    r_stat_pkt <= r_stat_pkt + 32'd1;
                end
                if (vld_user2interface[i] && r_cfg_valid && !w_grant[i]) begin
                    r_stat_stall <= r_stat_stall + 32'd1;
                end
            end
        end

        assign stat_pkt_count[i*32 +: 32]   = r_stat_pkt;
        assign stat_stall_count[i*32 +: 32] = r_stat_stall;
`endif
    end

    // ------------------------------------------------------------------
    // Output packet register and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout   <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_dout <= resend ? '0 : w_pkt_or[NUM_OUT_PORTS-1];
            if (|w_grant) begin
                r_rr_ptr <= w_ptr_or[NUM_OUT_PORTS-1];
            end
        end
    end

    assign ack_interface2user = w_grant;

    // Resend blanks the stream immediately, not just from the next edge.
    assign dout_leaf_interface2bft = resend ? '0 : r_dout;

endmodule
`default_nettype wire

// File: tb/tb_leaf_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_leaf_out_arbiter
//  Description : Self-checking bench for leaf_out_arbiter with a behavioural
//                reference model (round-robin search, credit arithmetic,
//                destination table) kept in plain integer arrays.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_out_arbiter;
    import leaf_pkg::*;

    localparam int N   = 7;
    localparam int PB  = 32;
    localparam int PKB = 49;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*PB-1:0] din;
    logic [N-1:0]    vld;
    logic [N-1:0]    ack;
    logic            resend;
    logic            cfg_wr_en;
    logic [3:0]      cfg_port_sel;
    logic [4:0]      cfg_dest_leaf;
    logic [3:0]      cfg_dest_port;
    logic            credit_upd_vld;
    logic [3:0]      credit_upd_port;
    logic [PKB-1:0]  dout;
    logic [N-1:0]    credit_zero;
`ifdef LEAF_ARB_STATS_EN
    logic [N*32-1:0] stat_pkt_count;
    logic [N*32-1:0] stat_stall_count;
`endif

    always #5 clk = ~clk;

    leaf_out_arbiter #(
        .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5), .NUM_PORT_BITS(4),
        .NUM_ADDR_BITS(7), .NUM_OUT_PORTS(7), .NUM_BRAM_ADDR_BITS(7),
        .FREESPACE_UPDATE_SIZE(64)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .resend                  (resend),
        .cfg_wr_en               (cfg_wr_en),
        .cfg_port_sel            (cfg_port_sel),
        .cfg_dest_leaf           (cfg_dest_leaf),
        .cfg_dest_port           (cfg_dest_port),
        .credit_upd_vld          (credit_upd_vld),
        .credit_upd_port         (credit_upd_port),
        .dout_leaf_interface2bft (dout),
        .credit_zero             (credit_zero)
`ifdef LEAF_ARB_STATS_EN
       ,.stat_pkt_count          (stat_pkt_count),
        .stat_stall_count        (stat_stall_count)
`endif
    );

    // User payloads, held until accepted
    logic [PB-1:0] pay [N];
    always_comb begin
        din = '0;
        for (int i = 0; i < N; i++) din[i*PB +: PB] = pay[i];
    end

    // ---------------- reference model ----------------
    int             m_valid  [N];
    logic [4:0]     m_leaf   [N];
    logic [3:0]     m_port   [N];
    int             m_addr   [N];
    int             m_credit [N];
    int             m_ptr;
    logic [PKB-1:0] m_dout;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation of the latest cycle
    logic [N-1:0]   ga, ea, gc, ec;
    logic [PKB-1:0] gd, ed;
    int             gg;

    function automatic int model_grant();
        if (resend) return -1;
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (vld[idx] && m_valid[idx] != 0 && m_credit[idx] > 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_leaf[i] = '0; m_port[i] = '0;
            m_addr[i] = 0;  m_credit[i] = 128;
        end
        m_ptr  = 0;
        m_dout = '0;
    endtask

    task automatic model_commit(input int g);
        leaf_pkt_t p;
        int        c;
        if (g >= 0) begin
            p.valid     = 1'b1;
            p.dest_leaf = m_leaf[g];
            p.dest_port = m_port[g];
            p.addr      = 7'(m_addr[g]);
            p.payload   = pay[g];
            m_dout      = p;
            m_addr[g]   = (m_addr[g] + 1) % 128;
            m_ptr       = (g + 1) % N;
        end else begin
            m_dout = '0;
        end
        for (int i = 0; i < N; i++) begin
            c = m_credit[i] - ((g == i) ? 1 : 0)
              + ((credit_upd_vld && credit_upd_port == i) ? 64 : 0);
            m_credit[i] = (c > 128) ? 128 : c;
        end
        if (cfg_wr_en && cfg_port_sel < N) begin
            m_valid[cfg_port_sel] = 1;
            m_leaf[cfg_port_sel]  = cfg_dest_leaf;
            m_port[cfg_port_sel]  = cfg_dest_port;
        end
    endtask

    // Advances one clock: samples ack before the edge, dout/credit_zero
    // after it, and fills the expected values from the model.
    task automatic run_cycle();
        @(negedge clk);
        gg = model_grant();
        ga = ack;
        ea = (gg >= 0) ? 7'(1 << gg) : '0;
        @(posedge clk);
        if (reset) model_reset();
        else       model_commit(gg);
        #1;
        gd = dout;
        ed = resend ? '0 : m_dout;
        gc = credit_zero;
        for (int i = 0; i < N; i++) ec[i] = (m_credit[i] == 0);
    endtask

    task automatic idle_inputs();
        vld = '0; resend = 1'b0; cfg_wr_en = 1'b0; credit_upd_vld = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        vld   = '1;
        run_cycle();
        run_cycle();
        n_checks++; if (gd !== '0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", gd); end
        n_checks++; if (ga !== '0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ga); end
        n_checks++; if (gc !== '0) begin n_fail++; $display("FAIL reset_credit_zero got=%b exp=0", gc); end
        reset = 1'b0;
        vld   = '0;
        run_cycle();
        n_checks++; if (gd !== '0) begin n_fail++; $display("FAIL post_reset_dout got=%h exp=0", gd); end
    endtask

    task automatic test_single();
        logic [PKB-1:0] exp_pkt;
        cfg_wr_en = 1'b1; cfg_port_sel = 4'd0; cfg_dest_leaf = 5'd3; cfg_dest_port = 4'd2;
        run_cycle();
        cfg_wr_en = 1'b0;
        pay[0] = 32'hDEADBEEF;
        vld    = 7'b0000001;
        run_cycle();
        exp_pkt = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
        n_checks++; if (ga !== 7'b0000001) begin n_fail++; $display("FAIL single_ack got=%b exp=0000001", ga); end
        n_checks++; if (gd !== exp_pkt) begin n_fail++; $display("FAIL single_pkt0 got=%h exp=%h", gd, exp_pkt); end
        pay[0] = 32'h12345678;
        run_cycle();
        exp_pkt = {1'b1, 5'd3, 4'd2, 7'd1, 32'h12345678};
        n_checks++; if (gd !== exp_pkt) begin n_fail++; $display("FAIL single_pkt1 got=%h exp=%h", gd, exp_pkt); end
        n_checks++; if (gd !== ed) begin n_fail++; $display("FAIL single_model got=%h exp=%h", gd, ed); end
        vld = '0;
        run_cycle();
    endtask

    task automatic test_round_robin();
        int exp_order [6] = '{0, 2, 5, 0, 2, 5};
        int cfg_ports [3] = '{0, 2, 5};
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cfg_wr_en = 1'b1; cfg_port_sel = 4'(cfg_ports[k]);
            cfg_dest_leaf = 5'($urandom); cfg_dest_port = 4'($urandom);
            run_cycle();
        end
        cfg_wr_en = 1'b0;
        vld = 7'h7F;
        for (int k = 0; k < 6; k++) begin
            run_cycle();
            n_checks++; if (ga !== 7'(1 << exp_order[k])) begin n_fail++; $display("FAIL rr_order[%0d] got=%b exp_port=%0d", k, ga, exp_order[k]); end
            n_checks++; if (gd !== ed) begin n_fail++; $display("FAIL rr_pkt[%0d] got=%h exp=%h", k, gd, ed); end
            n_checks++; if (gd[PKB-1] !== 1'b1) begin n_fail++; $display("FAIL rr_no_idle[%0d] got=%b exp=1", k, gd[PKB-1]); end
            if (gg >= 0) pay[gg] = $urandom;
        end
        vld = '0;
        run_cycle();
    endtask

    task automatic test_credit();
        int seg_len  [10] = '{128, 4, 1, 66, 1, 54, 1, 74, 3, 130};
        int seg_v    [10] = '{1,   1, 1, 1,  0, 1,  1, 1,  0, 1};
        int seg_u    [10] = '{0,   0, 1, 0,  1, 0,  1, 0,  1, 0};
        int seg_acks [10] = '{128, 0, 0, 64, 0, 54, 1, 73, 0, 128};
        int seg_cz   [10] = '{1,   1, 0, 1,  0, 0,  0, 1,  0, 1};
        int acks;
        cfg_wr_en = 1'b1; cfg_port_sel = 4'd1; cfg_dest_leaf = 5'd9; cfg_dest_port = 4'd7;
        run_cycle();
        cfg_wr_en = 1'b0;
        credit_upd_port = 4'd1;
        for (int s = 0; s < 10; s++) begin
            vld            = seg_v[s] != 0 ? 7'b0000010 : 7'b0;
            credit_upd_vld = seg_u[s] != 0;
            acks = 0;
            for (int c = 0; c < seg_len[s]; c++) begin
                run_cycle();
                if (ga[1] === 1'b1) acks++;
                n_checks++; if (ga !== ea) begin n_fail++; $display("FAIL credit_ack seg%0d cyc%0d got=%b exp=%b", s, c, ga, ea); end
                n_checks++; if (gc !== ec) begin n_fail++; $display("FAIL credit_zero seg%0d cyc%0d got=%b exp=%b", s, c, gc, ec); end
                n_checks++; if (gd !== ed) begin n_fail++; $display("FAIL credit_pkt seg%0d cyc%0d got=%h exp=%h", s, c, gd, ed); end
                if (gg >= 0) pay[gg] = $urandom;
            end
            n_checks++; if (acks != seg_acks[s]) begin n_fail++; $display("FAIL credit_count seg%0d got=%0d exp=%0d", s, acks, seg_acks[s]); end
            n_checks++; if (gc[1] !== 1'(seg_cz[s])) begin n_fail++; $display("FAIL credit_zero_end seg%0d got=%b exp=%0d", s, gc[1], seg_cz[s]); end
        end
        idle_inputs();
        run_cycle();
    endtask

    task automatic test_resend();
        int recv_pay  [$];
        int recv_addr [$];
        int a0;
        int ctr;
        a0  = m_addr[0];
        ctr = 0;
        pay[0] = 32'(ctr);
        vld = 7'b0000001;
        for (int c = 0; c < 26; c++) begin
            resend = (c >= 8 && c < 13);
            if (c == 25) vld = '0;
            run_cycle();
            n_checks++; if (ga !== ea) begin n_fail++; $display("FAIL resend_ack cyc%0d got=%b exp=%b", c, ga, ea); end
            n_checks++; if (gd !== ed) begin n_fail++; $display("FAIL resend_pkt cyc%0d got=%h exp=%h", c, gd, ed); end
            if (resend) begin
                n_checks++; if (ga !== '0 || gd !== '0) begin n_fail++; $display("FAIL resend_block cyc%0d ack=%b dout=%h exp=0", c, ga, gd); end
            end
            if (gd[PKB-1] === 1'b1) begin
                recv_pay.push_back(int'(gd[31:0]));
                recv_addr.push_back(int'(gd[38:32]));
            end
            if (ga[0] === 1'b1) begin ctr++; pay[0] = 32'(ctr); end
        end
        resend = 1'b0;
        n_checks++; if (recv_pay.size() != 20) begin n_fail++; $display("FAIL resend_count got=%0d exp=20", recv_pay.size()); end
        for (int k = 0; k < recv_pay.size(); k++) begin
            n_checks++; if (recv_pay[k] != k || recv_addr[k] != (a0 + k) % 128) begin
                n_fail++; $display("FAIL resend_seq[%0d] got pay=%0d addr=%0d exp pay=%0d addr=%0d", k, recv_pay[k], recv_addr[k], k, (a0 + k) % 128);
            end
        end
    endtask

    task automatic test_unconfigured();
        int acks6 = 0;
        vld = 7'b1000000;
        for (int c = 0; c < 10; c++) begin
            cfg_wr_en      = (c == 3);
            cfg_port_sel   = 4'd9;
            cfg_dest_leaf  = 5'd17;
            cfg_dest_port  = 4'd6;
            credit_upd_vld = (c == 5);
            credit_upd_port = 4'd12;
            run_cycle();
            if (ga[6] === 1'b1) acks6++;
            n_checks++; if (ga !== ea) begin n_fail++; $display("FAIL uncfg_ack cyc%0d got=%b exp=%b", c, ga, ea); end
            n_checks++; if (gd !== ed) begin n_fail++; $display("FAIL uncfg_pkt cyc%0d got=%h exp=%h", c, gd, ed); end
        end
        n_checks++; if (acks6 != 0) begin n_fail++; $display("FAIL uncfg_port6_acks got=%0d exp=0", acks6); end
        idle_inputs();
        run_cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset           = (c == 200);
            vld             = 7'($urandom);
            resend          = ($urandom_range(0, 9) == 0);
            cfg_wr_en       = ($urandom_range(0, 7) == 0);
            cfg_port_sel    = 4'($urandom_range(0, 15));
            cfg_dest_leaf   = 5'($urandom);
            cfg_dest_port   = 4'($urandom);
            credit_upd_vld  = ($urandom_range(0, 5) == 0);
            credit_upd_port = 4'($urandom_range(0, 15));
            run_cycle();
            n_checks++; if (ga !== ea) begin n_fail++; $display("FAIL rand_ack cyc%0d got=%b exp=%b", c, ga, ea); end
            n_checks++; if (gd !== ed) begin n_fail++; $display("FAIL rand_pkt cyc%0d got=%h exp=%h", c, gd, ed); end
            n_checks++; if (gc !== ec) begin n_fail++; $display("FAIL rand_credit_zero cyc%0d got=%b exp=%b", c, gc, ec); end
            if (gg >= 0) pay[gg] = $urandom;
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        cfg_port_sel = '0; cfg_dest_leaf = '0; cfg_dest_port = '0; credit_upd_port = '0;
        for (int i = 0; i < N; i++) pay[i] = $urandom;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_credit();
        test_resend();
        test_unconfigured();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
Parametrised output half of the leaf shell. Merges NUM_OUT_PORTS user output streams (payload, vld, ack) into the single BFT-facing packet stream.
- Round-robin arbitration across ports.
- Per-port destination table and per-port sequence addresses.
- Per-port credit (freespace) flow control.
- Resend gating.
Generalises the fixed i4o7 shell output side to any port count and width. Sits between the user kernel and the BFT leaf port.

Parameters:
- PACKET_BITS, 49, packet width; must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS.
- PAYLOAD_BITS, 32, user word width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width; also the width of config/credit port selects.
- NUM_ADDR_BITS, 7, per-port sequence address width.
- NUM_OUT_PORTS, 7, user output channels (1..2^NUM_PORT_BITS).
- NUM_BRAM_ADDR_BITS, 7, remote buffer depth log2; initial credit = 2^NUM_BRAM_ADDR_BITS.
- FREESPACE_UPDATE_SIZE, 64, credits returned per update.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  payloads; port i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_user2interface  in  NUM_OUT_PORTS  per-port valid.
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept, one-hot or zero.
- resend  in  1  BFT resend request; blocks issue.
- cfg_wr_en  in  1  destination table write.
- cfg_port_sel  in  NUM_PORT_BITS  table entry index.
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf.
- cfg_dest_port  in  NUM_PORT_BITS  destination port.
- credit_upd_vld  in  1  freespace update strobe.
- credit_upd_port  in  NUM_PORT_BITS  port receiving the update.
- dout_leaf_interface2bft  out  PACKET_BITS  registered packet.
- credit_zero  out  NUM_OUT_PORTS  per-port "no credit" status.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Packet format: [MSB]=valid, then dest_leaf, dest_port, addr, payload (LSBs).
- Reset values:
  - dout = 0, ack = 0.
  - All table entries invalid, dest fields 0.
  - addr counters 0.
  - credits = 2^NUM_BRAM_ADDR_BITS; credit_zero = 0.
  - rr pointer = 0.
- Eligibility: port i is eligible iff vld[i] && cfg_valid[i] && credit[i]!=0 && !resend.
- Grant: combinational. Search eligible ports starting at rr pointer, ascending, wrapping.
- ack_interface2user[i] = grant[i] in the same cycle. A transfer occurs on vld&&ack. Users hold payload until ack.
- Next edge after a grant:
  - dout = {1, dest_leaf[i], dest_port[i], addr[i], payload[i]}.
  - addr[i]++ (wraps 2^NUM_ADDR_BITS-1 -> 0).
  - credit[i]--.
  - rr pointer = i+1 mod NUM_OUT_PORTS.
- No grant: dout = 0 (valid bit clear) next edge; rr pointer holds.
- Latency: 1 cycle from ack to packet. Throughput: 1 packet/cycle max.
- resend high: no grants. dout is forced to 0 combinationally at the output mux; the register contents are also cleared next edge.
- Credits:
  - Counter width NUM_BRAM_ADDR_BITS+1.
  - On credit_upd_vld, add FREESPACE_UPDATE_SIZE, saturating at 2^NUM_BRAM_ADDR_BITS.
  - Send and update on the same port in the same cycle: net +FREESPACE_UPDATE_SIZE-1, then saturate.
  - credit_zero[i] = (credit[i]==0), registered view of the counter.
- Out-of-range indices: cfg_port_sel or credit_upd_port >= NUM_OUT_PORTS is ignored.
- Config write to a port granted in the same cycle: packet uses old entry; new entry applies from next cycle. Writing an entry sets cfg_valid and does not reset addr.
- Reset mid-packet: the packet is dropped; all state returns to reset values next edge.

Optional Feature:
LEAF_ARB_STATS_EN
- Defined: adds output stat_pkt_count (NUM_OUT_PORTS*32) and output stat_stall_count (NUM_OUT_PORTS*32).
  - stat_pkt_count[i] counts packets sent.
  - stat_stall_count[i] counts cycles with vld[i]&&cfg_valid[i] and no grant.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package leaf_pkg:
  - Packet field offset/width localparams derived from the parameters.
  - Credit width function.
  - Packet struct typedef (valid, dest_leaf, dest_port, addr, payload).
- One sub-module, leaf_rr_arbiter (NUM_REQ parameter): request vector + pointer in, one-hot grant out.
- Credit and address counters stay inline.

Test Plan:
- Reset, then cfg port0 -> leaf 3/port 2; vld0 with 0xDEADBEEF -> ack0 same cycle; next cycle dout = {1,5'd3,4'd2,7'd0,32'hDEADBEEF}; second word gets addr 1.
- Ports 0,2,5 configured and all vld continuously -> grant order 0,2,5,0,2,5; one packet per cycle; no idle cycles.
- Port 1 sends 128 words with no updates -> credit_zero[1]=1 after 128th; no ack while zero; one update -> 64 more accepted.
- Update and send on port 1 in the same cycle at credit 10 -> credit 73; update at credit 128 -> stays 128 (saturate).
- resend asserted mid-burst for 5 cycles -> ack=0 and dout=0 throughout; stream resumes at the next addr with no word lost or duplicated.
- Unconfigured port 6 with vld=1 -> never acked; cfg_port_sel=9 write -> ignored, port 6 still never granted.
